aes_key_schedule: RTL and testbench
===================================

// Module: aes_key_schedule
// PURPOSE
//  Multi-length AES key expander (AES-128/192/256, FIPS-197) feeding the round datapath.
//  Generates one 32-bit schedule word per cycle and packs them into 128-bit round keys.
//  Round keys leave on a valid/ready stream: rk0 (the cipher key) first, then rk1..rkNr.
//  Replaces the fixed 128-bit expander. Adds on-the-fly Rcon, backpressure and an error flag.
// PARAMETERS
//  MAX_NK  8  largest key length built, in 32-bit words: 4 = AES-128 only, 6 = up to 192, 8 = all.
//  KEY_W   32*MAX_NK  width of the key port (derived; do not override).
// PORTS
//  CLK       in   1      clock; all flops update on the rising edge.
//  RST_N     in   1      asynchronous reset, active-low.
//  start     in   1      request a new expansion; accepted only in IDLE.
//  key_len   in   2      0 = 128 (Nk 4, Nr 10), 1 = 192 (Nk 6, Nr 12), 2 = 256 (Nk 8, Nr 14), 3 = illegal.
//  key       in   KEY_W  cipher key, left-aligned: key[KEY_W-1 -: 32] = w0; unused LSBs ignored.
//  busy      out  1      high from the accept edge until the final round key is taken.
//  rk_valid  out  1      rk, rk_idx and rk_last are valid.
//  rk_ready  in   1      consumer takes rk on the edge where rk_valid && rk_ready.
//  rk        out  128    round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}; w[4r] is in the MSBs.
//  rk_idx    out  4      round number r of the presented key, 0..Nr.
//  rk_last   out  1      high together with rk_valid when rk_idx == Nr.
//  err       out  1      one-cycle pulse when start is rejected.
// BEHAVIOUR
//  Reset (RST_N low, any time, including mid-expansion):
//   - all outputs go to 0 and the FSM goes to IDLE; in-flight data is discarded.
//  FSM states: IDLE, RUN, LAST.
//   - IDLE -> RUN when start is high and key_len is legal (Nk <= MAX_NK).
//   - RUN -> LAST after word 4*(Nr+1)-1 is written.
//   - LAST -> IDLE on the handshake of rk_last.
//  Start rejected in IDLE: key_len == 3, or Nk > MAX_NK.
//   - err pulses 1 cycle after the edge; state stays IDLE.
//  Start while busy: ignored, no err pulse.
//  Key and key_len are sampled only on the accept edge (E0); later changes have no effect.
//  Word generation (counter i from 0, window of the last Nk words):
//   - i < Nk: w[i] = key word i.
//   - else t = w[i-1]:
//       i mod Nk == 0:                t = SubWord(RotWord(t)) ^ {rcon, 24'h0}.
//       Nk == 8 and i mod 8 == 4:     t = SubWord(t).
//     Then w[i] = w[i-Nk] ^ t.
//   - rcon: starts at 8'h01 on accept; after each use rcon = xtime(rcon)
//     (shift left 1; XOR 8'h1b if bit 7 was set).
//   - SubWord uses 4 byte-wide S-box instances, shared by both SubWord cases.
//  Packing:
//   - One word enters the 4-slot packer per edge.
//   - rk_valid rises on the edge that fills slot 3.
//   - Generation stalls while rk_valid && !rk_ready.
//   - On a handshake edge, the next word goes straight into slot 0 (no bubble).
//  Timing with rk_ready tied high:
//   - rk0 is valid after E4; rk r is valid after E(4r+4).
//   - AES-128 last key after E44, AES-192 after E52, AES-256 after E60.
//   - busy falls the edge after the rk_last handshake; a new start is accepted on that next edge.
//  Outputs hold stable while rk_valid && !rk_ready.
//   - rk_idx increments per handshake and wraps to 0 on return to IDLE.
// TESTING
//  AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1
//   -> rk0 = key; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at E44 with rk_last=1.
//  AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b
//   -> rk12 = e98ba06f448c773c8ecc720401002202, rk_idx=12, rk_last=1.
//  AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4
//   -> rk14 = fe4890d1e6188d0b046df344706c631e.
//  Backpressure: AES-128, rk_ready random 30% high
//   -> identical rk sequence to the first test; rk stable while stalled; exactly 11 handshakes.
//  Rejects: key_len=3 in IDLE -> err 1 cycle, busy=0; start while busy -> ignored, sequence unchanged.
//   With MAX_NK=4, key_len=2 -> err pulse.
//  Reset: RST_N low after rk3 -> all outputs 0 asynchronously.
//   Next start -> fresh rk0 = new key and rcon restarts at 01.

Source files
------------

// File: rtl/aes_key_schedule.sv
// aes_key_schedule
//   Multi-length AES key expander (AES-128/192/256). One 32-bit schedule word
//   is generated per cycle. Words are packed four at a time into 128-bit round
//   keys, which leave on a valid/ready stream: rk0 (the cipher key) first,
//   then rk1..rkNr.
//
// Ports
//   CLK       in   clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   start     in   request a new expansion (accepted only when idle)
//   key_len   in   0=128, 1=192, 2=256, 3=illegal
//   key       in   cipher key, left-aligned (MSB word is w0)
//   busy      out  high from accept until the last round key is taken
//   rk_valid  out  rk/rk_idx/rk_last are valid
//   rk_ready  in   consumer accepts rk when rk_valid && rk_ready
//   rk        out  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   rk_idx    out  round number of the presented key
//   rk_last   out  presented key is the final round key
//   err       out  one-cycle pulse when a start is rejected

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        logic [7:0] bb;
        acc = '0;
        x   = a;
        bb  = b;
        for (int unsigned k = 0; k < 8; k++) begin
            if (bb[0]) acc = acc ^ x;
            x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return acc;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
    always_comb begin
        inv = 8'h01;
        sq  = a_i;
        for (int unsigned k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_schedule #(
    parameter int unsigned MAX_NK = 8,
    parameter int unsigned KEY_W  = 32 * MAX_NK
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     rk,
    output logic [3:0]       rk_idx,
    output logic             rk_last,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

    state_t           state_q;
    logic [KEY_W-1:0] key_q;
    logic [31:0]      win_q [MAX_NK];   // win_q[0] is the newest word
    logic [31:0]      slot_q [3];
    logic [1:0]       cnt_q;
    logic [5:0]       i_q;
    logic [2:0]       mod_q;            // i mod Nk
    logic [3:0]       nk_q;
    logic [3:0]       nk_m1_q;
    logic [5:0]       last_i_q;
    logic [7:0]       rcon_q;
    logic [127:0]     rk_q;
    logic             rk_valid_q;
    logic             rk_last_q;
    logic [3:0]       rk_idx_q;
    logic             busy_q;
    logic             err_q;

    logic [3:0]  len_nk;
    logic [5:0]  len_last;
    logic        len_ok;
    logic        gen_en;
    logic        from_key;
    logic        hs;
    logic [31:0] prev;
    logic [31:0] oldest;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] t;
    logic [31:0] word_d;

    always_comb begin
        len_nk   = 4'd4;
        len_last = 6'd43;
        case (key_len)
            2'd1: begin len_nk = 4'd6; len_last = 6'd51; end
            2'd2: begin len_nk = 4'd8; len_last = 6'd59; end
            default: ;
        endcase
        len_ok = (key_len != 2'd3) && (len_nk <= MAX_NK_L);
    end

    assign prev   = win_q[0];
    assign sub_in = (mod_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    // One S-box bank serves both the RotWord and the AES-256 mid-block SubWord.
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a_i(sub_in[8*g +: 8]), .y_o(sub_out[8*g +: 8]));
    end

    always_comb begin
        gen_en   = (state_q == RUN) && !(rk_valid_q && !rk_ready);
        hs       = rk_valid_q && rk_ready;
        from_key = i_q < {2'b00, nk_q};
        oldest   = win_q[0];
        for (int unsigned k = 0; k < MAX_NK; k++) begin
            if (4'(k) == nk_m1_q) oldest = win_q[k];
        end
        if (mod_q == 3'd0)                        t = sub_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && mod_q == 3'd4)   t = sub_out;
        else                                      t = prev;
        word_d = from_key ? key_q[KEY_W-1 -: 32] : (oldest ^ t);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            key_q      <= '0;
            for (int unsigned k = 0; k < MAX_NK; k++) win_q[k] <= '0;
            for (int unsigned k = 0; k < 3; k++) slot_q[k] <= '0;
            cnt_q      <= '0;
            i_q        <= '0;
            mod_q      <= '0;
            nk_q       <= '0;
            nk_m1_q    <= '0;
            last_i_q   <= '0;
            rcon_q     <= '0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            rk_idx_q   <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            // Handshake clears first so a same-edge slot-3 fill below wins.
            if (hs) begin
                rk_valid_q <= 1'b0;
                rk_last_q  <= 1'b0;
                rk_idx_q   <= rk_last_q ? '0 : rk_idx_q + 4'd1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            key_q    <= key;
                            nk_q     <= len_nk;
                            nk_m1_q  <= len_nk - 4'd1;
                            last_i_q <= len_last;
                            i_q      <= '0;
                            mod_q    <= '0;
                            rcon_q   <= 8'h01;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (gen_en) begin
                        key_q    <= {key_q[KEY_W-33:0], 32'h0};
                        win_q[0] <= word_d;
                        for (int unsigned k = 1; k < MAX_NK; k++) win_q[k] <= win_q[k-1];
                        i_q   <= i_q + 6'd1;
                        mod_q <= ({1'b0, mod_q} == nk_m1_q) ? '0 : mod_q + 3'd1;
                        if (!from_key && mod_q == 3'd0)
                            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                        case (cnt_q)
                            2'd0: slot_q[0] <= word_d;
                            2'd1: slot_q[1] <= word_d;
                            2'd2: slot_q[2] <= word_d;
                            default: begin
                                rk_q       <= {slot_q[0], slot_q[1], slot_q[2], word_d};
                                rk_valid_q <= 1'b1;
                                rk_last_q  <= (i_q == last_i_q);
                            end
                        endcase
                        cnt_q <= cnt_q + 2'd1;
                        if (i_q == last_i_q) state_q <= LAST;
                    end
                end
                LAST: begin
                    if (hs) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk       = rk_q;
    assign rk_idx   = rk_idx_q;
    assign rk_last  = rk_last_q;
    assign err      = err_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule
//   Self-checking bench for aes_key_schedule. Expected round keys come from a
//   table-driven reference expansion and are queued when a start is driven,
//   then compared against each round key the DUT presents.

module tb_aes_key_schedule;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         err;

    logic         start4;
    logic [1:0]   key_len4;
    logic [127:0] key4;
    logic         busy4;
    logic         rk_valid4;
    logic         rk_ready4;
    logic [127:0] rk4;
    logic [3:0]   rk_idx4;
    logic         rk_last4;
    logic         err4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [127:0] rk;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    exp_t sbq[$];

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] R192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] KSEQ = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RSEQ = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic [2047:0] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    always #5 clk = ~clk;

    aes_key_schedule #(.MAX_NK(8)) dut (
        .CLK(clk), .RST_N(rst_n), .start(start), .key_len(key_len), .key(key),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk),
        .rk_idx(rk_idx), .rk_last(rk_last), .err(err));

    aes_key_schedule #(.MAX_NK(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .start(start4), .key_len(key_len4), .key(key4),
        .busy(busy4), .rk_valid(rk_valid4), .rk_ready(rk_ready4), .rk(rk4),
        .rk_idx(rk_idx4), .rk_last(rk_last4), .err(err4));

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_tab[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    task automatic push_expected(input logic [255:0] k, input logic [1:0] len);
        logic [31:0] w [60];
        logic [79:0] rct;
        logic [31:0] t;
        int nk;
        int nr;
        exp_t e;
        rct = 80'h01020408102040801b36;
        nk  = 4 + 2*int'(len);
        nr  = nk + 6;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = k[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0)
                    t = subw({t[23:0], t[31:24]}) ^ {rct[79-8*(i/nk-1) -: 8], 24'h0};
                else if (nk == 8 && i % nk == 4)
                    t = subw(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            e.rk   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            e.idx  = 4'(r);
            e.last = (r == nr);
            sbq.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge E0.
    task automatic do_start(input logic [255:0] k, input logic [1:0] len);
        key     = k;
        key_len = len;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        key     = ~k;
        key_len = 2'd3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; key = '0; key_len = '0; rk_ready = 1'b1;
        start4 = 1'b0; key4 = '0; key_len4 = '0; rk_ready4 = 1'b1;
        #1;
        checks++;
        if ({busy, rk_valid, rk, rk_idx, rk_last, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b vld=%b rk=%h idx=%0d last=%b err=%b required all 0",
                     busy, rk_valid, rk, rk_idx, rk_last, err);
        end
        checks++;
        if ({busy4, rk_valid4, rk4, rk_idx4, rk_last4, err4} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_nk4: got busy=%b vld=%b rk=%h required all 0", busy4, rk_valid4, rk4);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors(input string name, input logic [255:0] k, input logic [1:0] len,
                                input logic [127:0] final_rk, input bit inject);
        int   nr;
        int   cyc;
        int   hs;
        bit   done;
        bit   err_seen;
        exp_t e;
        nr = 10 + 2*int'(len);
        push_expected(k, len);
        rk_ready = 1'b1;
        do_start(k, len);
        cyc = 0; hs = 0; done = 1'b0; err_seen = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept: got %b required 1", name, busy);
        end
        while (!done && cyc < 200) begin
            if (err) err_seen = 1'b1;
            if (rk_valid) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s unexpected_rk: got rk=%h idx=%0d required no key", name, rk, rk_idx);
                    done = 1'b1;
                end else begin
                    e = sbq.pop_front();
                    checks++;
                    if ({rk, rk_idx, rk_last} !== e) begin
                        errors++;
                        $display("FAIL %s rk%0d: got rk=%h idx=%0d last=%b required rk=%h idx=%0d last=%b",
                                 name, e.idx, rk, rk_idx, rk_last, e.rk, e.idx, e.last);
                    end
                    checks++;
                    if (cyc != 4*int'(e.idx) + 4) begin
                        errors++;
                        $display("FAIL %s rk%0d_timing: got edge %0d required edge %0d", name, e.idx, cyc, 4*int'(e.idx)+4);
                    end
                    if (e.last) begin
                        checks++;
                        if (rk !== final_rk) begin
                            errors++;
                            $display("FAIL %s final_vector: got %h required %h", name, rk, final_rk);
                        end
                        done = 1'b1;
                    end
                    hs++;
                end
            end
            if (inject) begin
                start = (cyc == 10);
                if (cyc == 10) begin
                    key     = ~k ^ 256'h5a5a;
                    key_len = 2'd0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: got %0d handshakes in %0d cycles required %0d", name, hs, cyc, nr+1);
        end
        checks++;
        if ({busy, rk_valid, rk_idx} !== 6'b0) begin
            errors++;
            $display("FAIL %s end_state: got busy=%b vld=%b idx=%0d required 0 0 0", name, busy, rk_valid, rk_idx);
        end
        checks++;
        if (hs != nr + 1) begin
            errors++;
            $display("FAIL %s handshakes: got %0d required %0d", name, hs, nr+1);
        end
        checks++;
        if (err_seen !== 1'b0) begin
            errors++;
            $display("FAIL %s err_during_run: got 1 required 0", name);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s leftover: got %0d pending keys required 0", name, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_backpressure();
        int   cyc;
        int   hs;
        bit   done;
        bit   rdy;
        exp_t e;
        push_expected({K128, 128'h0}, 2'd0);
        do_start({K128, 128'h0}, 2'd0);
        cyc = 0; hs = 0; done = 1'b0;
        while (!done && cyc < 2000) begin
            rdy = ($urandom_range(0, 99) < 30);
            if (rk_valid) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bp unexpected_rk: got rk=%h required no key", rk);
                    done = 1'b1;
                end else begin
                    checks++;
                    if ({rk, rk_idx, rk_last} !== sbq[0]) begin
                        errors++;
                        $display("FAIL bp rk%0d: got rk=%h idx=%0d last=%b required rk=%h idx=%0d last=%b",
                                 sbq[0].idx, rk, rk_idx, rk_last, sbq[0].rk, sbq[0].idx, sbq[0].last);
                    end
                    if (rdy) begin
                        e = sbq.pop_front();
                        hs++;
                        if (e.last) done = 1'b1;
                    end
                end
            end
            rk_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        rk_ready = 1'b1;
        if (!done) begin
            checks++; errors++;
            $display("FAIL bp timeout: got %0d handshakes required 11", hs);
        end
        checks++;
        if (hs != 11) begin
            errors++;
            $display("FAIL bp handshakes: got %0d required 11", hs);
        end
        checks++;
        if ({busy, rk_valid} !== 2'b00) begin
            errors++;
            $display("FAIL bp end_state: got busy=%b vld=%b required 0 0", busy, rk_valid);
        end
        sbq.delete();
    endtask

    task automatic test_rejects();
        key = 256'hdeadbeef; key_len = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reject_len3: got err=%b busy=%b required err=1 busy=0", err, busy);
        end
        @(negedge clk);
        checks++;
        if ({err, busy, rk_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reject_pulse_width: got err=%b busy=%b vld=%b required 0 0 0", err, busy, rk_valid);
        end
    endtask

    task automatic test_max_nk4();
        int cyc;
        bit last_seen;
        key4 = K128; key_len4 = 2'd2; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        checks++;
        if ({err4, busy4} !== 2'b10) begin
            errors++;
            $display("FAIL nk4_reject_256: got err=%b busy=%b required err=1 busy=0", err4, busy4);
        end
        @(negedge clk);
        checks++;
        if (err4 !== 1'b0) begin
            errors++;
            $display("FAIL nk4_err_width: got %b required 0", err4);
        end
        key_len4 = 2'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        checks++;
        if ({err4, busy4} !== 2'b10) begin
            errors++;
            $display("FAIL nk4_reject_192: got err=%b busy=%b required err=1 busy=0", err4, busy4);
        end
        key_len4 = 2'd0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        checks++;
        if ({err4, busy4} !== 2'b01) begin
            errors++;
            $display("FAIL nk4_accept_128: got err=%b busy=%b required err=0 busy=1", err4, busy4);
        end
        cyc = 0; last_seen = 1'b0;
        while (busy4 && cyc < 100) begin
            if (rk_valid4 && rk_last4) begin
                last_seen = 1'b1;
                checks++;
                if ({rk4, rk_idx4} !== {R128, 4'd10}) begin
                    errors++;
                    $display("FAIL nk4_final: got rk=%h idx=%0d required rk=%h idx=10", rk4, rk_idx4, R128);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({busy4, last_seen} !== 2'b01) begin
            errors++;
            $display("FAIL nk4_completion: got busy=%b last_seen=%b required 0 1", busy4, last_seen);
        end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        int   hs;
        exp_t e;
        push_expected({K128, 128'h0}, 2'd0);
        rk_ready = 1'b1;
        do_start({K128, 128'h0}, 2'd0);
        cyc = 0; hs = 0;
        while (hs < 4 && cyc < 100) begin
            if (rk_valid) begin
                e = sbq.pop_front();
                checks++;
                if ({rk, rk_idx, rk_last} !== e) begin
                    errors++;
                    $display("FAIL rstmid rk%0d: got rk=%h idx=%0d required rk=%h idx=%0d", e.idx, rk, rk_idx, e.rk, e.idx);
                end
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        if (hs < 4) begin
            checks++; errors++;
            $display("FAIL rstmid timeout: got %0d handshakes required 4", hs);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, rk_valid, rk, rk_idx, rk_last, err} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got busy=%b vld=%b rk=%h idx=%0d last=%b err=%b required all 0",
                     busy, rk_valid, rk, rk_idx, rk_last, err);
        end
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_vectors("fresh_after_reset", {KSEQ, 128'h0}, 2'd0, RSEQ, 1'b0);
    endtask

    initial begin
        test_reset();
        test_vectors("aes128", {K128, 128'h0}, 2'd0, R128, 1'b0);
        test_vectors("aes192_start_while_busy", {K192, 64'h0}, 2'd1, R192, 1'b1);
        test_vectors("aes256_back_to_back", K256, 2'd2, R256, 1'b0);
        test_backpressure();
        test_rejects();
        test_max_nk4();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
